hart_step_ctrl: RTL

//  Central execute-enable sequencer for the RISCuin core: replaces the ad-hoc pc_enable

---
 rtl/hart_step_ctrl_pkg.sv | 13 +
 rtl/hart_step_ctrl_pause_timer.sv | 29 ++
 rtl/hart_step_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/hart_step_ctrl_pkg.sv
// Shared definitions for the hart execute-enable sequencer: FSM state width and encodings.
package hart_step_ctrl_pkg;

  localparam int STATE_W = 3;

  // These encodings are visible on the state port and must not be renumbered.
  localparam logic [STATE_W-1:0] ST_WAIT  = 3'd0;
  localparam logic [STATE_W-1:0] ST_RUN   = 3'd1;
  localparam logic [STATE_W-1:0] ST_STALL = 3'd2;
  localparam logic [STATE_W-1:0] ST_PAUSE = 3'd3;
  localparam logic [STATE_W-1:0] ST_HALT  = 3'd4;

endpackage

// File: rtl/hart_step_ctrl_pause_timer.sv
// Down-counter for Zihintpause timing: load a start value, decrement to zero, and flag zero.
module hart_step_ctrl_pause_timer #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 dec,
  input  logic                 clear,
  output logic                 zero
);

  logic [CNT_WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/hart_step_ctrl.sv
// Execute-enable sequencer: arbitrates ready, stall channels, bus wait and pause timing into step_en.
// Optional build macro RISCUIN_INSTRET_EN adds a 64-bit retired-step counter port (instret).
module hart_step_ctrl
  import hart_step_ctrl_pkg::*;
#(
  parameter int NUM_STALL    = 2,
  parameter int PAUSE_CYCLES = 16,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rb_ready,
  input  logic                 bus_ready,
  input  logic                 bus_busy,
  input  logic                 pause_req,
  input  logic [NUM_STALL-1:0] stall_req,
  input  logic                 pc_end,
  output logic                 step_en,
  output logic [STATE_W-1:0]   state,
  output logic                 pause_active,
  output logic                 halted,
  output logic                 pause_err,
  output logic [CNT_WIDTH-1:0] stall_cycles
`ifdef RISCUIN_INSTRET_EN
  ,
  output logic [63:0]          instret
`endif
);

  // With PAUSE_CYCLES == 0 a pause instruction simply retires like a nop.
  localparam bit PAUSE_EN = (PAUSE_CYCLES > 0);
  localparam logic [CNT_WIDTH-1:0] PAUSE_LOAD = PAUSE_EN ? CNT_WIDTH'(PAUSE_CYCLES - 1) : '0;

  logic [STATE_W-1:0] state_nxt;
  logic blocked;
  logic timer_load, timer_dec, timer_clear, timer_zero;

  assign blocked      = !bus_ready || bus_busy || (|stall_req);
  assign step_en      = (state == ST_RUN) && !blocked && !pc_end && !rst;
  assign pause_active = (state == ST_PAUSE);
  assign halted       = (state == ST_HALT);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    timer_load  = 1'b0;
    timer_dec   = 1'b0;
    timer_clear = 1'b0;
    case (state)
      ST_WAIT: begin
        if (rb_ready && bus_ready) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!rb_ready)     state_nxt = ST_WAIT;
        else if (pc_end)   state_nxt = ST_HALT;
        else if (blocked)  state_nxt = ST_STALL;
        else if (pause_req && PAUSE_EN) begin
          state_nxt  = ST_PAUSE;
          timer_load = 1'b1;
        end
      end
      ST_STALL: begin
        if (!rb_ready)     state_nxt = ST_WAIT;
        else if (pc_end)   state_nxt = ST_HALT;
        else if (!blocked) state_nxt = ST_RUN;
      end
      ST_PAUSE: begin
        // Bus and stall requests are deliberately ignored while the pause runs out.
        if (!rb_ready) begin
          state_nxt   = ST_WAIT;
          timer_clear = 1'b1;
        end else if (timer_zero) begin
          state_nxt = ST_RUN;
        end else begin
          timer_dec = 1'b1;
        end
      end
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_WAIT;
      pause_err    <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ST_PAUSE) && pause_req) pause_err <= 1'b1;
      if ((state == ST_STALL) && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_WIDTH'(1);
    end
  end

  hart_step_ctrl_pause_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_pause_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (PAUSE_LOAD),
    .dec      (timer_dec),
    .clear    (timer_clear),
    .zero     (timer_zero)
  );

`ifdef RISCUIN_INSTRET_EN
  always_ff @(posedge clk) begin
    if (rst)          instret <= '0;
    else if (step_en) instret <= instret + 64'd1;
  end
`endif

endmodule
